// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN image loader: FSM state encoding and default sizes.
// No logic here; the error digit is what a watchdog expiry reports as the classification.
package snn_pkg;

  typedef enum logic [2:0] {
    LOAD,
    UNPACK,
    START,
    WAIT,
    RESULT
  } state_e;

  localparam int          NUM_PIXELS_DEF = 784;
  localparam int          ADDR_WIDTH_DEF = 10;
  localparam logic [3:0]  DIGIT_ERR      = 4'hF;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Byte-wide load/shift register that serialises one pixel per shift; bit_o is valid the cycle after load_i.
// No backpressure: the owner shifts exactly once per written pixel; last_bit_o flags the eighth bit.
module snn_byte_unpacker #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_i,
  output logic       bit_o,
  output logic       last_bit_o
);

  logic [7:0] shreg_q;
  logic [2:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
      idx_q   <= '0;
    end else if (shift_i) begin
      shreg_q <= (LSB_FIRST != 0) ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};
      idx_q   <= idx_q + 3'd1;
    end
  end

  assign bit_o      = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[7];
  assign last_bit_o = (idx_q == 3'd7);

endmodule

// File: rtl/snn_image_loader.sv
// Unpacks a byte stream into the 1-bit input RAM (1 accept + 8 write cycles per byte), starts snn_core, returns its digit.
// byte_ready is high only in LOAD; result is held until result_ready. Watchdog on core_done under SNN_LOADER_TIMEOUT_EN.
module snn_image_loader
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS     = NUM_PIXELS_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int LSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  ram_we,
  output logic                  ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [3:0]            core_digit,
  output logic [3:0]            result_digit,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]            digit_q, digit_d;
  logic                  byte_ready_q, busy_q, ram_we_q, core_start_q, result_valid_q;
  logic                  unpk_load, unpk_shift, unpk_bit, unpk_last;

`ifdef SNN_LOADER_TIMEOUT_EN
  localparam int       TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  snn_byte_unpacker #(
    .LSB_FIRST (LSB_FIRST)
  ) u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .load_i     (unpk_load),
    .data_i     (byte_data),
    .shift_i    (unpk_shift),
    .bit_o      (unpk_bit),
    .last_bit_o (unpk_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    unpk_load  = 1'b0;
    unpk_shift = 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      LOAD: begin
        if (byte_valid) begin
          unpk_load = 1'b1;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        unpk_shift = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        // Image end wins over byte end: trailing bits of the final byte are dropped.
        if (cnt_q == LAST_PIX) begin
          state_d = START;
        end else if (unpk_last) begin
          state_d = LOAD;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          digit_d = core_digit;
          state_d = RESULT;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          digit_d = DIGIT_ERR;
          state_d = RESULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESULT: begin
        if (result_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Output flags are registered decodes of the next state, so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD;
      cnt_q          <= '0;
      digit_q        <= '0;
      byte_ready_q   <= 1'b1;
      busy_q         <= 1'b0;
      ram_we_q       <= 1'b0;
      core_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      digit_q        <= digit_d;
      byte_ready_q   <= (state_d == LOAD);
      busy_q         <= (state_d != LOAD);
      ram_we_q       <= (state_d == UNPACK);
      core_start_q   <= (state_d == START);
      result_valid_q <= (state_d == RESULT);
`ifdef SNN_LOADER_TIMEOUT_EN
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign busy         = busy_q;
  assign ram_we       = ram_we_q;
  assign ram_data     = ram_we_q & unpk_bit;
  assign ram_addr     = (state_q == LOAD || state_q == UNPACK) ? cnt_q : core_addr;
  assign core_start   = core_start_q;
  assign result_valid = result_valid_q;
  assign result_digit = digit_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed bench for snn_image_loader: full 784-pixel image, core handshake, abort by reset,
// and a short 10-pixel instance for the truncated-final-byte case.
module tb_snn_image_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_data;
  logic       byte_valid, byte_ready, ram_we, ram_data, core_start, core_done;
  logic [9:0] ram_addr, core_addr;
  logic [3:0] core_digit, result_digit;
  logic       result_valid, result_ready, busy;

  logic [7:0] b_byte_data;
  logic       b_byte_valid, b_byte_ready, b_ram_we, b_ram_data, b_core_start, b_core_done;
  logic [9:0] b_ram_addr, b_core_addr;
  logic [3:0] b_core_digit, b_result_digit;
  logic       b_result_valid, b_result_ready, b_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snn_image_loader u_dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .ram_we(ram_we), .ram_data(ram_data), .ram_addr(ram_addr), .core_addr(core_addr),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .result_digit(result_digit), .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
  );

  snn_image_loader #(.NUM_PIXELS(10)) u_dut10 (
    .clk(clk), .rst(rst), .byte_data(b_byte_data), .byte_valid(b_byte_valid), .byte_ready(b_byte_ready),
    .ram_we(b_ram_we), .ram_data(b_ram_data), .ram_addr(b_ram_addr), .core_addr(b_core_addr),
    .core_start(b_core_start), .core_done(b_core_done), .core_digit(b_core_digit),
    .result_digit(b_result_digit), .result_valid(b_result_valid), .result_ready(b_result_ready), .busy(b_busy)
  );

  // Shadow RAM and event counters, sampled on the edge the DUT writes on.
  logic mem [0:1023];
  logic b_mem [0:1023];
  int cyc = 0, we_cnt = 0, last_we = 0, start_cnt = 0, start_cyc = 0;
  int acc_cnt = 0, last_acc = 0, gap_viol = 0, br_viol = 0;
  int b_we = 0, b_last_we = 0, b_start = 0, b_start_cyc = 0, b_acc = 0, b_max_addr = 0, b_ones = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_we) begin
      mem[ram_addr] = ram_data;
      we_cnt  = we_cnt + 1;
      last_we = cyc;
    end
    if (ram_we && byte_ready) br_viol = br_viol + 1;
    if (core_start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
    if (byte_valid && byte_ready) begin
      if (acc_cnt > 0 && cyc - last_acc != 9) gap_viol = gap_viol + 1;
      acc_cnt  = acc_cnt + 1;
      last_acc = cyc;
    end
    if (b_ram_we) begin
      b_mem[b_ram_addr] = b_ram_data;
      b_we      = b_we + 1;
      b_last_we = cyc;
      if (b_ram_data) b_ones = b_ones + 1;
      if (int'(b_ram_addr) > b_max_addr) b_max_addr = int'(b_ram_addr);
    end
    if (b_core_start) begin
      b_start     = b_start + 1;
      b_start_cyc = cyc;
    end
    if (b_byte_valid && b_byte_ready) b_acc = b_acc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  int a0, w0, s0, g0, v0, w1;

  initial begin
    rst = 1'b1;
    byte_data = '0; byte_valid = 1'b0; core_addr = 10'h155; core_done = 1'b0; core_digit = '0;
    result_ready = 1'b0;
    b_byte_data = '0; b_byte_valid = 1'b0; b_core_addr = '0; b_core_done = 1'b0; b_core_digit = '0;
    b_result_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_byte_ready",   32'(byte_ready),   1);
    chk("rst_ram_we",       32'(ram_we),       0);
    chk("rst_ram_data",     32'(ram_data),     0);
    chk("rst_core_start",   32'(core_start),   0);
    chk("rst_result_digit", 32'(result_digit), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_busy",         32'(busy),         0);
    rst = 1'b0;

    // Image of 98 x A5 with byte_valid held high throughout.
    a0 = acc_cnt; w0 = we_cnt; s0 = start_cnt; g0 = gap_viol; v0 = br_viol;
    byte_data = 8'hA5; byte_valid = 1'b1;
    for (int k = 0; k < 2000 && acc_cnt - a0 < 98; k++) @(negedge clk);
    byte_valid = 1'b0;
    chk("bytes_accepted", acc_cnt - a0, 98);
    for (int k = 0; k < 100 && start_cnt == s0; k++) @(negedge clk);
    chk("write_count",  we_cnt - w0, 784);
    chk("pix0",   32'(mem[0]),   1);
    chk("pix1",   32'(mem[1]),   0);
    chk("pix2",   32'(mem[2]),   1);
    chk("pix5",   32'(mem[5]),   1);
    chk("pix6",   32'(mem[6]),   0);
    chk("pix7",   32'(mem[7]),   1);
    chk("pix783", 32'(mem[783]), 1);
    chk("start_pulses", start_cnt - s0, 1);
    chk("start_after_last_write", start_cyc - last_we, 1);
    chk("accept_every_9", gap_viol - g0, 0);
    chk("ready_low_in_unpack", br_viol - v0, 0);
    @(negedge clk);
    chk("start_single_cycle", start_cnt - s0, 1);
    chk("wait_addr_mux",   32'(ram_addr),     32'h155);
    chk("wait_busy",       32'(busy),         1);
    chk("wait_byte_ready", 32'(byte_ready),   0);
    chk("wait_no_result",  32'(result_valid), 0);

    // Core answers 8 about 50 cycles after start.
    repeat (47) @(negedge clk);
    core_done = 1'b1; core_digit = 4'd8;
    @(negedge clk);
    core_done = 1'b0; core_digit = 4'd0;
    chk("result_valid", 32'(result_valid), 1);
    chk("result_digit", 32'(result_digit), 8);

    a0 = acc_cnt;
    byte_data = 8'h3C; byte_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid",      32'(result_valid), 1);
      chk("hold_digit",      32'(result_digit), 8);
      chk("result_no_ready", 32'(byte_ready),   0);
    end
    chk("no_accept_in_result", acc_cnt - a0, 0);
    byte_valid = 1'b0; result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("valid_cleared",   32'(result_valid), 0);
    chk("back_to_load",    32'(byte_ready),   1);
    chk("idle_not_busy",   32'(busy),         0);

    // Done outside WAIT must be ignored.
    core_done = 1'b1; core_digit = 4'd3;
    repeat (2) @(negedge clk);
    core_done = 1'b0; core_digit = 4'd0;
    chk("stray_done_valid", 32'(result_valid), 0);
    chk("stray_done_busy",  32'(busy),         0);
    chk("stray_done_digit", 32'(result_digit), 8);

    // Second image of zeros, aborted by reset mid-byte.
    w0 = we_cnt;
    byte_data = 8'h00; byte_valid = 1'b1;
    for (int k = 0; k < 1000 && we_cnt - w0 < 403; k++) @(negedge clk);
    chk("pre_abort_writes", we_cnt - w0, 403);
    rst = 1'b1;
    #1;
    chk("abort_ram_we",       32'(ram_we),       0);
    chk("abort_ram_data",     32'(ram_data),     0);
    chk("abort_byte_ready",   32'(byte_ready),   1);
    chk("abort_busy",         32'(busy),         0);
    chk("abort_core_start",   32'(core_start),   0);
    chk("abort_result_valid", 32'(result_valid), 0);
    chk("abort_result_digit", 32'(result_digit), 0);
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    w1 = we_cnt;
    byte_data = 8'h03; byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("restart_writes", we_cnt - w1, 8);
    chk("restart_pix0", 32'(mem[0]), 1);
    chk("restart_pix1", 32'(mem[1]), 1);
    chk("restart_pix2", 32'(mem[2]), 0);

    // 10-pixel instance: second FF byte is cut after two bits.
    b_byte_data = 8'hFF; b_byte_valid = 1'b1;
    for (int k = 0; k < 100 && b_acc < 2; k++) @(negedge clk);
    b_byte_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("short_accepts",     b_acc, 2);
    chk("short_writes",      b_we, 10);
    chk("short_ones",        b_ones, 10);
    chk("short_max_addr",    b_max_addr, 9);
    chk("short_pix9",        32'(b_mem[9]), 1);
    chk("short_start",       b_start, 1);
    chk("short_start_after", b_start_cyc - b_last_we, 1);
    chk("short_wait_busy",   32'(b_busy), 1);
    chk("short_wait_ready",  32'(b_byte_ready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
